pixel_readout: RTL and testbench



---
 rtl/pixel_readout_pkg.sv | 18 +
 rtl/pixel_readout_if.sv | 28 ++
 rtl/pixel_readout_sync_fifo.sv | 54 +++++
 rtl/pixel_readout.sv | 175 +++++++++++++++++
 tb/tb_pixel_readout.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_readout_pkg.sv
// pixel_readout shared types: FSM states and FIFO entry layout.
// Imported by the interface, the FIFO and the top.
package pixel_readout_pkg;

  localparam int PR_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    READ
  } state_t;

  typedef struct packed {
    logic [PR_DATA_BITS-1:0] data;
    logic                    last;
  } fifo_entry_t;

endpackage

// File: rtl/pixel_readout_if.sv
// pixel_readout output stream: valid/ready with a frame-end tag.
// master drives data/valid/last, slave drives ready.
interface pixel_readout_if
  import pixel_readout_pkg::*;
#(
  parameter int DATA_BITS = PR_DATA_BITS
) ();

  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pixel_readout_sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-two depth.
// A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_q];

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (rd_en) rd_q <= rd_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: ramp capture per pixel, row push into an output FIFO.
// Optional PIXEL_READOUT_TEST_PATTERN_EN adds test_mode (index pattern).
module pixel_readout
  import pixel_readout_pkg::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = 2,
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int DATA_BITS          = PR_DATA_BITS,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic convert,
  input  logic [DATA_BITS-1:0] d_ramp,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_ARRAY_HEIGHT-1:0] comp,
  input  logic read,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0] row_select,
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  output logic overflow,
  pixel_readout_if.master out
);

  localparam int W  = PIXEL_ARRAY_WIDTH;
  localparam int H  = PIXEL_ARRAY_HEIGHT;
  localparam int N  = W * H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t               state_q;
  logic                 conv_q;
  logic [DATA_BITS-1:0] samp_q [N];
  logic [N-1:0]         flag_q;
  logic [H-1:0]         rs_q;
  logic [H-1:0]         rs_prev_q;
  logic                 push_q;
  logic [CW-1:0]        col_q;
  logic [IW-1:0]        pix_q;
  logic                 last_row_q;
  logic                 done_q;
  logic                 ovf_q;

  logic           conv_rise;
  logic           conv_fall;
  logic           tmode;
  logic           rs_ok;
  logic           chg;
  logic           in_prog;
  logic           col_end;
  logic           drop;
  logic [IW-1:0]  start_pix;
  logic [DATA_BITS:0] wr_ent;
  logic [DATA_BITS:0] rd_ent;
  logic           f_full;
  logic           f_empty;

  assign conv_rise = convert && !conv_q;
  assign conv_fall = !convert && conv_q;

`ifdef PIXEL_READOUT_TEST_PATTERN_EN
  assign tmode = test_mode;
`else
  assign tmode = 1'b0;
`endif

  assign rs_ok   = (rs_q != '0) && ((rs_q & (rs_q - H'(1))) == '0);
  assign chg     = (state_q == READ) && rs_ok && (rs_q != rs_prev_q);
  assign col_end = (col_q == CW'(W - 1));
  assign in_prog = push_q && !col_end;
  assign drop    = push_q && f_full && !out.out_ready;
  assign wr_ent  = {samp_q[pix_q], last_row_q && col_end};

  // first flat pixel index of the newly selected row
  always_comb begin
    start_pix = '0;
    for (int r = 0; r < H; r++) begin
      if (rs_q[r]) start_pix = IW'(r * W);
    end
  end

  // per-pixel ramp capture, saturation at convert end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_q <= 1'b0;
      flag_q <= '0;
      for (int i = 0; i < N; i++) samp_q[i] <= '0;
    end else begin
      conv_q <= convert;
      for (int i = 0; i < N; i++) begin
        if (conv_rise) begin
          flag_q[i] <= 1'b0;
        end else if (conv_fall) begin
          if (tmode) samp_q[i] <= DATA_BITS'(i);
          else if (!flag_q[i]) samp_q[i] <= '1;
          flag_q[i] <= 1'b1;
        end else if (convert && comp[i] && !flag_q[i]) begin
          samp_q[i] <= d_ramp;
          flag_q[i] <= 1'b1;
        end
      end
    end
  end

  // row change detection and column walk of the push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_q       <= '0;
      rs_prev_q  <= '0;
      push_q     <= 1'b0;
      col_q      <= '0;
      pix_q      <= '0;
      last_row_q <= 1'b0;
    end else begin
      rs_q      <= row_select;
      rs_prev_q <= rs_q;
      if (conv_rise) begin
        push_q <= 1'b0;
      end else if (chg) begin
        push_q     <= 1'b1;
        col_q      <= '0;
        pix_q      <= start_pix;
        last_row_q <= rs_q[H-1];
      end else if (push_q) begin
        col_q <= col_q + CW'(1);
        pix_q <= pix_q + IW'(1);
        if (col_end) push_q <= 1'b0;
      end
    end
  end

  // frame FSM, sticky overflow, last-row-pushed flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (conv_rise) ovf_q <= 1'b0;
      else if ((chg && in_prog) || drop) ovf_q <= 1'b1;
      if (conv_rise) done_q <= 1'b0;
      else if (push_q && last_row_q && col_end) done_q <= 1'b1;
      if (convert) begin
        state_q <= CONVERT;
      end else begin
        unique case (state_q)
          IDLE:    ;
          CONVERT: if (read) state_q <= READ;
          READ:    if (done_q && f_empty && !push_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_q),
    .data_i  (wr_ent),
    .pop_i   (out.out_ready),
    .data_o  (rd_ent),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign out.out_valid = !f_empty;
  assign out.out_data  = f_empty ? '0 : rd_ent[DATA_BITS:1];
  assign out.out_last  = !f_empty && rd_ent[0];
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: table vectors, corner sequences, random frames.
// Two DUTs share stimulus: FIFO depth 4 and depth 2.
module tb_pixel_readout;
  import pixel_readout_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       convert;
  logic       read;
  logic       rdy;
  logic [7:0] d_ramp;
  logic [3:0] comp;
  logic [1:0] row_select;
  logic       ovf4;
  logic       ovf2;
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
  logic       test_mode;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fifo_entry_t got4[$];
  fifo_entry_t got2[$];

  always #5 clk = ~clk;

  pixel_readout_if #(.DATA_BITS(8)) if4 ();
  pixel_readout_if #(.DATA_BITS(8)) if2 ();
  assign if4.out_ready = rdy;
  assign if2.out_ready = rdy;

  pixel_readout #(
    .PIXEL_ARRAY_WIDTH(2), .PIXEL_ARRAY_HEIGHT(2),
    .DATA_BITS(8), .FIFO_DEPTH(4)
  ) u4 (
    .clk(clk), .reset(reset), .convert(convert),
    .d_ramp(d_ramp), .comp(comp), .read(read),
    .row_select(row_select),
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .overflow(ovf4), .out(if4)
  );

  pixel_readout #(
    .PIXEL_ARRAY_WIDTH(2), .PIXEL_ARRAY_HEIGHT(2),
    .DATA_BITS(8), .FIFO_DEPTH(2)
  ) u2 (
    .clk(clk), .reset(reset), .convert(convert),
    .d_ramp(d_ramp), .comp(comp), .read(read),
    .row_select(row_select),
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .overflow(ovf2), .out(if2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // expected sample from the capture rules alone
  function automatic int model(input int i, input int thr[4],
                               input int mx, input bit tm);
    if (tm) return i;
    if (thr[i] <= mx) return thr[i];
    return 255;
  endfunction

  // record accepted beats, check hold while stalled
  logic       p4s, p2s, p4l, p2l;
  logic [7:0] p4d, p2d;
  always @(negedge clk) begin
    if (!reset) begin
      p4s = 1'b0;
      p2s = 1'b0;
    end else begin
      if (p4s) begin
        chk("hold4 valid", if4.out_valid, 1);
        chk("hold4 data", if4.out_data, p4d);
        chk("hold4 last", if4.out_last, p4l);
      end
      if (p2s) begin
        chk("hold2 valid", if2.out_valid, 1);
        chk("hold2 data", if2.out_data, p2d);
        chk("hold2 last", if2.out_last, p2l);
      end
      p4s = if4.out_valid && !rdy;
      p4d = if4.out_data;
      p4l = if4.out_last;
      p2s = if2.out_valid && !rdy;
      p2d = if2.out_data;
      p2l = if2.out_last;
      if (if4.out_valid && rdy)
        got4.push_back('{data: if4.out_data, last: if4.out_last});
      if (if2.out_valid && rdy)
        got2.push_back('{data: if2.out_data, last: if2.out_last});
    end
  end

  task automatic run_convert(input int thr[4], input int mx,
                             input bit tm);
    rdy = 1'b1;
    read = 1'b0;
    row_select = '0;
    comp = '0;
    d_ramp = '0;
    convert = 1'b1;
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
    test_mode = tm;
`endif
    step();
    chk("ovf clear d4", ovf4, 0);
    chk("ovf clear d2", ovf2, 0);
    for (int k = 0; k <= mx + 1; k++) begin
      if (k == mx + 1) convert = 1'b0;
      d_ramp = 8'(k);
      for (int i = 0; i < 4; i++)
        comp[i] = (k == thr[i]) ? 1'b1 :
                  (k > thr[i]) ? 1'($urandom) : 1'b0;
      step();
    end
    comp = '0;
  endtask

  task automatic read_rows(input bit stall);
    read = 1'b1;
    rdy = !stall;
    step();
    row_select = 2'b01;
    repeat (4) step();
    row_select = 2'b10;
    step();
    read = 1'b0;
    repeat (3) step();
  endtask

  task automatic drain(input bit rnd);
    int t;
    t = 0;
    while ((if4.out_valid || if2.out_valid) && t < 300) begin
      rdy = rnd ? 1'($urandom) : 1'b1;
      step();
      t++;
    end
    if (t >= 300) chk("drain timeout", t, 0);
    rdy = 1'b1;
  endtask

  task automatic cmp_q(input string tag, input fifo_entry_t q[$],
                       input int ex[4], input int n);
    chk({tag, " count"}, q.size(), n);
    for (int j = 0; j < n && j < q.size(); j++) begin
      chk($sformatf("%s beat%0d data", tag, j), q[j].data, ex[j]);
      chk($sformatf("%s beat%0d last", tag, j), q[j].last, (j == 3));
    end
  endtask

  task automatic frame(input int thr[4], input int mx, input bit tm,
                       input bit st, input bit rr, input int ex[4],
                       input string tag);
    got4.delete();
    got2.delete();
    run_convert(thr, mx, tm);
    read_rows(st);
    drain(rr);
    cmp_q({tag, "/d4"}, got4, ex, 4);
    cmp_q({tag, "/d2"}, got2, ex, st ? 2 : 4);
    chk({tag, "/ovf d4"}, ovf4, 0);
    chk({tag, "/ovf d2"}, ovf2, st);
  endtask

  typedef struct {
    int thr[4];
    int mx;
    bit st;
    int ex[4];
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    int rthr[4];
    int rex[4];
    int rmx;
    bit rst_b;
    bit rtm;

    tbl[0].thr = '{10, 50, 100, 200};
    tbl[0].mx = 255; tbl[0].st = 1'b0;
    tbl[0].ex = '{10, 50, 100, 200};
    tbl[1].thr = '{10, 50, 300, 200};
    tbl[1].mx = 255; tbl[1].st = 1'b0;
    tbl[1].ex = '{10, 50, 255, 200};
    tbl[2].thr = '{20, 40, 60, 80};
    tbl[2].mx = 255; tbl[2].st = 1'b1;
    tbl[2].ex = '{20, 40, 60, 80};
    tbl[3].thr = '{0, 255, 128, 254};
    tbl[3].mx = 254; tbl[3].st = 1'b0;
    tbl[3].ex = '{0, 255, 128, 254};
    tbl[4].thr = '{5, 6, 7, 8};
    tbl[4].mx = 3; tbl[4].st = 1'b1;
    tbl[4].ex = '{255, 255, 255, 255};

    reset = 1'b0;
    convert = 1'b0;
    read = 1'b0;
    rdy = 1'b0;
    row_select = '0;
    comp = '0;
    d_ramp = '0;
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid d4", if4.out_valid, 0);
    chk("rst last d4", if4.out_last, 0);
    chk("rst data d4", if4.out_data, 0);
    chk("rst ovf d4", ovf4, 0);
    chk("rst valid d2", if2.out_valid, 0);
    chk("rst ovf d2", ovf2, 0);
    reset = 1'b1;
    step();

    for (int v = 0; v < 5; v++)
      frame(tbl[v].thr, tbl[v].mx, 1'b0, tbl[v].st, 1'b0,
            tbl[v].ex, $sformatf("vec%0d", v));

    // latency: row change at edge N, data after N+2
    run_convert(tbl[0].thr, 255, 1'b0);
    read = 1'b1;
    rdy = 1'b1;
    step();
    row_select = 2'b01;
    step();
    chk("lat N valid", if4.out_valid, 0);
    step();
    chk("lat N+1 valid", if4.out_valid, 0);
    step();
    chk("lat N+2 valid", if4.out_valid, 1);
    chk("lat N+2 data", if4.out_data, 10);
    repeat (3) step();

    // new row change while a push is in flight
    got4.delete();
    row_select = 2'b10;
    step();
    row_select = 2'b01;
    repeat (6) step();
    drain(1'b0);
    chk("abort ovf d4", ovf4, 1);
    n = got4.size();
    chk("abort beats>=2", int'(n >= 2), 1);
    if (n >= 2) begin
      chk("abort tail0 data", got4[n-2].data, 10);
      chk("abort tail1 data", got4[n-1].data, 50);
      chk("abort tail1 last", got4[n-1].last, 0);
    end

    // non-one-hot and all-zero selects push nothing
    row_select = 2'b11;
    repeat (5) step();
    chk("multi-hot valid", if4.out_valid, 0);
    row_select = 2'b00;
    repeat (4) step();
    chk("zero sel valid", if4.out_valid, 0);

    // asynchronous reset with a last-tagged head pending
    run_convert(tbl[0].thr, 255, 1'b0);
    read_rows(1'b1);
    rdy = 1'b1;
    repeat (3) step();
    rdy = 1'b0;
    chk("pre-rst valid d4", if4.out_valid, 1);
    chk("pre-rst last d4", if4.out_last, 1);
    chk("pre-rst data d4", if4.out_data, 200);
    chk("pre-rst ovf d2", ovf2, 1);
    #2 reset = 1'b0;
    #1;
    chk("async rst valid d4", if4.out_valid, 0);
    chk("async rst last d4", if4.out_last, 0);
    chk("async rst data d4", if4.out_data, 0);
    chk("async rst ovf d2", ovf2, 0);
    chk("async rst valid d2", if2.out_valid, 0);
    step();
    reset = 1'b1;
    step();
    frame(tbl[1].thr, 255, 1'b0, 1'b0, 1'b0, tbl[1].ex, "post-rst");

`ifdef PIXEL_READOUT_TEST_PATTERN_EN
    rex = '{0, 1, 2, 3};
    frame(tbl[0].thr, 255, 1'b1, 1'b0, 1'b0, rex, "tpat");
`endif

    // random frames against the reference model
    for (int f = 0; f < 10; f++) begin
      rmx = $urandom_range(255, 0);
      for (int i = 0; i < 4; i++) rthr[i] = $urandom_range(299, 0);
      rst_b = 1'($urandom);
      rtm = 1'b0;
`ifdef PIXEL_READOUT_TEST_PATTERN_EN
      rtm = 1'($urandom);
`endif
      for (int i = 0; i < 4; i++) rex[i] = model(i, rthr, rmx, rtm);
      frame(rthr, rmx, rtm, rst_b, 1'b1, rex,
            $sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
